trigger_capture: RTL

Triggered, double-buffered waveform capture stage between an ADC channel (CH0–CH7) and the VGA waveform renderer. It writes a continuous stream of samples into a circular buffer and detects a level-crossing trigger. After a full screen-width frame that includes pre-trigger history, it swaps banks so the renderer always reads a complete, stable frame. The renderer supplies `screenX` and receives `screenData`, replacing the free-running per-column sampler on a channel path.

---
 rtl/trigger_capture.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/trigger_capture.sv
// Triggered, double-buffered waveform capture: circular write into a capture bank,
// level-crossing trigger, bank swap per frame. Optional auto-trigger: `define TRIG_AUTO_EN.
module trigger_capture #(
    parameter int unsigned DATA_W       = 12,
    parameter int unsigned DEPTH        = 640,
    parameter int unsigned PRE_TRIG     = 64,
    parameter int unsigned AUTO_TIMEOUT = 4096
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_rising,
    input  logic              run,
    input  logic              force_trig,
    input  logic [10:0]       screenX,
    output logic [DATA_W-1:0] screenData,
    output logic              frame_done,
    output logic              frame_valid,
    output logic [1:0]        cap_state
);

    localparam int unsigned AW     = 10;
    localparam int unsigned IW     = AW + 1;
    localparam int unsigned POST_N = DEPTH - PRE_TRIG - 1;

    if (DEPTH > 1024 || DEPTH < 2 || PRE_TRIG >= DEPTH || AUTO_TIMEOUT < 1) begin : g_bad_params
        $error("trigger_capture: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRETRIG   = 2'd1,
        WAIT_TRIG = 2'd2,
        POST      = 2'd3
    } state_t;

    // Reduce a sum of two in-range indices (always < 2*DEPTH) back into 0..DEPTH-1.
    function automatic logic [AW-1:0] wrap_idx(input logic [IW-1:0] s);
        logic [IW-1:0] r;
        r = (s >= IW'(DEPTH)) ? s - IW'(DEPTH) : s;
        return r[AW-1:0];
    endfunction

    state_t            state_q, state_d;
    logic [AW-1:0]     wp_q, wp_d, cnt_q, cnt_d;
    logic [AW-1:0]     start_q, start_d, disp_start_q, disp_start_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic              prev_ok_q, prev_ok_d, force_pend_q, force_pend_d;
    logic              bank_sel_q, bank_sel_d, frame_done_q, frame_done_d;
    logic              frame_valid_q, frame_valid_d, rd_zero_q, rd_zero_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [AW-1:0]     rd_addr;
    logic              wr_en, rise_hit, fall_hit, edge_hit, auto_hit, trig_hit;
    logic              swap, restart;

    logic [DATA_W-1:0] mem0 [DEPTH];
    logic [DATA_W-1:0] mem1 [DEPTH];

    assign wr_en    = sample_valid && (state_q != IDLE);
    assign rise_hit = prev_ok_q && (prev_q < trig_level) && (sample_data >= trig_level);
    assign fall_hit = prev_ok_q && (prev_q >= trig_level) && (sample_data < trig_level);
    assign edge_hit = trig_rising ? rise_hit : fall_hit;
    assign trig_hit = edge_hit || force_pend_q || force_trig || auto_hit;

`ifdef TRIG_AUTO_EN
    localparam int unsigned TO_W = $clog2(AUTO_TIMEOUT + 1);
    logic [TO_W-1:0] to_q, to_d;

    // Counter is held at zero outside WAIT_TRIG, so every entry starts a fresh timeout.
    always_comb begin
        to_d = '0;
        if (state_q == WAIT_TRIG) to_d = sample_valid ? to_q + TO_W'(1) : to_q;
    end
    assign auto_hit = (state_q == WAIT_TRIG) && (to_q == TO_W'(AUTO_TIMEOUT - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) to_q <= '0;
        else        to_q <= to_d;
    end
`else
    assign auto_hit = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        wp_d          = wp_q;
        cnt_d         = cnt_q;
        prev_d        = prev_q;
        prev_ok_d     = prev_ok_q;
        force_pend_d  = force_pend_q;
        start_d       = start_q;
        disp_start_d  = disp_start_q;
        bank_sel_d    = bank_sel_q;
        frame_done_d  = 1'b0;
        frame_valid_d = frame_valid_q;
        swap          = 1'b0;
        restart       = 1'b0;

        if (sample_valid) begin
            prev_d    = sample_data;
            prev_ok_d = 1'b1;
        end
        if (wr_en) wp_d = wrap_idx({1'b0, wp_q} + IW'(1));

        case (state_q)
            IDLE: restart = run;
            PRETRIG: begin
                if (sample_valid) begin
                    if (cnt_q == AW'(PRE_TRIG - 1)) begin
                        state_d = WAIT_TRIG;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + AW'(1);
                    end
                end
            end
            WAIT_TRIG: begin
                force_pend_d = force_pend_q | force_trig;
                if (sample_valid) begin
                    force_pend_d = 1'b0;
                    if (trig_hit) begin
                        start_d = wrap_idx({1'b0, wp_q} + IW'(DEPTH - PRE_TRIG));
                        cnt_d   = '0;
                        if (POST_N == 0) swap = 1'b1;
                        else             state_d = POST;
                    end
                end
            end
            POST: begin
                if (sample_valid) begin
                    if (cnt_q == AW'(POST_N - 1)) swap = 1'b1;
                    else                          cnt_d = cnt_q + AW'(1);
                end
            end
        endcase

        // A completed frame always swaps; otherwise dropping run discards the frame.
        if (swap) begin
            bank_sel_d    = ~bank_sel_q;
            disp_start_d  = start_d;
            frame_done_d  = 1'b1;
            frame_valid_d = 1'b1;
            if (run) restart = 1'b1;
            else     state_d = IDLE;
        end else if (!run && state_q != IDLE) begin
            state_d = IDLE;
        end

        if (restart) begin
            wp_d      = '0;
            cnt_d     = '0;
            prev_ok_d = 1'b0;
            state_d   = (PRE_TRIG == 0) ? WAIT_TRIG : PRETRIG;
        end
        if (state_d != WAIT_TRIG) force_pend_d = 1'b0;
    end

    always_comb begin
        rd_addr = disp_start_q;
        if (screenX < 11'(DEPTH)) rd_addr = wrap_idx({1'b0, disp_start_q} + IW'(screenX));
        rd_zero_d = (screenX >= 11'(DEPTH)) || !frame_valid_q;
        rd_data_d = bank_sel_q ? mem1[rd_addr] : mem0[rd_addr];
    end

    // bank_sel names the display bank; the other bank is the capture bank.
    always_ff @(posedge clock) begin
        if (wr_en && !bank_sel_q) mem1[wp_q] <= sample_data;
        if (wr_en && bank_sel_q)  mem0[wp_q] <= sample_data;
        rd_data_q <= rd_data_d;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            wp_q          <= '0;
            cnt_q         <= '0;
            start_q       <= '0;
            disp_start_q  <= '0;
            prev_q        <= '0;
            prev_ok_q     <= 1'b0;
            force_pend_q  <= 1'b0;
            bank_sel_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_valid_q <= 1'b0;
            rd_zero_q     <= 1'b1;
        end else begin
            state_q       <= state_d;
            wp_q          <= wp_d;
            cnt_q         <= cnt_d;
            start_q       <= start_d;
            disp_start_q  <= disp_start_d;
            prev_q        <= prev_d;
            prev_ok_q     <= prev_ok_d;
            force_pend_q  <= force_pend_d;
            bank_sel_q    <= bank_sel_d;
            frame_done_q  <= frame_done_d;
            frame_valid_q <= frame_valid_d;
            rd_zero_q     <= rd_zero_d;
        end
    end

    assign screenData  = rd_zero_q ? '0 : rd_data_q;
    assign frame_done  = frame_done_q;
    assign frame_valid = frame_valid_q;
    assign cap_state   = state_q;

endmodule
